// File: rtl/lgu_pkg.sv
// -----------------------------------------------------------------------------
// lgu_pkg
// Shared types and constants for the logic gate unit.
//   op_e          : 4-bit opcode encoding of the ten legal bitwise functions;
//                   codes 0xA..0xF are illegal.
//   LGU_ERR_CNT_W : width of the saturating illegal-opcode counter.
//   lgu_is_legal  : returns 1 when an opcode selects one of the ten functions.
// -----------------------------------------------------------------------------
package lgu_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_NOT_A = 4'd2,
      OP_NOT_B = 4'd3,
      OP_XOR   = 4'd4,
      OP_XNOR  = 4'd5,
      OP_BUF_A = 4'd6,
      OP_BUF_B = 4'd7,
      OP_NAND  = 4'd8,
      OP_NOR   = 4'd9
   } op_e;

   localparam int unsigned LGU_ERR_CNT_W = 8;

   function automatic logic lgu_is_legal(input op_e op);
      return (op <= OP_NOR);
   endfunction

endpackage

// File: rtl/lgu_fifo.sv
// -----------------------------------------------------------------------------
// lgu_fifo
// Circular-buffer FIFO with an explicit occupancy counter.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push/wdata : write request and data (ignored when full)
//   pop/rdata  : read request (ignored when empty) and head data
//   full/empty : occupancy flags
//   count      : current occupancy, 0..DEPTH
// Pointers wrap from DEPTH-1 to 0 (DEPTH is a power of two). Storage is not
// reset; the consumer is expected to qualify rdata with !empty.
// -----------------------------------------------------------------------------
module lgu_fifo #(
   parameter int unsigned DW    = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            wdata,
   input  logic                     pop,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];

endmodule

// File: rtl/logic_gate_unit.sv
// -----------------------------------------------------------------------------
// logic_gate_unit
// Applies one of ten bitwise logic functions to two WIDTH-bit operands and
// buffers {result, err} in a DEPTH-entry FIFO behind valid/ready handshakes.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : input handshake; in_ready = FIFO not full
//   in_op, in_a, in_b    : opcode (lgu_pkg::op_e encoding) and operands
//   out_valid/out_ready  : output handshake; out_valid = FIFO not empty
//   out_result, out_err  : head result and illegal-opcode flag (0 when empty)
//   count                : FIFO occupancy
//   err_cnt              : saturating count of accepted illegal opcodes
//   out_parity           : XOR-reduce of out_result, only with LGU_PARITY_EN
// Optional feature macro: LGU_PARITY_EN.
// -----------------------------------------------------------------------------
module logic_gate_unit
   import lgu_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_op,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   count,
   output logic [LGU_ERR_CNT_W-1:0] err_cnt
`ifdef LGU_PARITY_EN
   ,
   output logic                     out_parity
`endif
);

`ifdef LGU_PARITY_EN
   localparam int unsigned DW = WIDTH + 2;
`else
   localparam int unsigned DW = WIDTH + 1;
`endif

   logic [WIDTH-1:0] calc_result;
   logic             calc_err;
   logic             accept;
   logic [DW-1:0]    wdata;
   logic [DW-1:0]    rdata;
   logic             fifo_full;
   logic             fifo_empty;

   always_comb begin
      calc_result = '0;
      calc_err    = !lgu_is_legal(op_e'(in_op));
      case (in_op)
         OP_AND:   calc_result = in_a & in_b;
         OP_OR:    calc_result = in_a | in_b;
         OP_NOT_A: calc_result = ~in_a;
         OP_NOT_B: calc_result = ~in_b;
         OP_XOR:   calc_result = in_a ^ in_b;
         OP_XNOR:  calc_result = ~(in_a ^ in_b);
         OP_BUF_A: calc_result = in_a;
         OP_BUF_B: calc_result = in_b;
         OP_NAND:  calc_result = ~(in_a & in_b);
         OP_NOR:   calc_result = ~(in_a | in_b);
         default:  calc_result = '0;
      endcase
   end

   assign accept = in_valid && in_ready;

`ifdef LGU_PARITY_EN
   assign wdata = {^calc_result, calc_err, calc_result};
`else
   assign wdata = {calc_err, calc_result};
`endif

   lgu_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .wdata (wdata),
      .pop   (out_ready),
      .rdata (rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   assign in_ready  = !fifo_full;
   assign out_valid = !fifo_empty;

   // Storage is not reset, so the head fields are forced to 0 when empty.
   assign out_result = out_valid ? rdata[WIDTH-1:0] : '0;
   assign out_err    = out_valid ? rdata[WIDTH]     : 1'b0;
`ifdef LGU_PARITY_EN
   assign out_parity = out_valid ? rdata[WIDTH+1]   : 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (accept && calc_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + LGU_ERR_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_logic_gate_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_unit
// Directed-vector bench for logic_gate_unit with WIDTH=8, DEPTH=4.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_logic_gate_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic       out_err;
   logic [2:0] count;
   logic [7:0] err_cnt;
`ifdef LGU_PARITY_EN
   logic       out_parity;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_ops [10] = '{8'h48, 8'hDE, 8'h35, 8'hA3, 8'h96,
                                8'h69, 8'hCA, 8'h5C, 8'hB7, 8'h21};

   logic_gate_unit #(
      .WIDTH (8),
      .DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .count      (count),
      .err_cnt    (err_cnt)
`ifdef LGU_PARITY_EN
      ,
      .out_parity (out_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      tick();
      tick();

      // Reset state
      check("rst_count", count, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_err", out_err, 0);
      rst_n = 1'b1;

      // All ten ops, streaming with out_ready=1: each result is head one cycle later
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'(i), 8'hCA, 8'h5C);
         tick();
         check($sformatf("op%0d_valid", i), out_valid, 1);
         check($sformatf("op%0d_result", i), out_result, exp_ops[i]);
         check($sformatf("op%0d_err", i), out_err, 0);
         check($sformatf("op%0d_count", i), count, 1);
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      tick();
      check("ops_drained", count, 0);
      check("ops_out_result_gated", out_result, 0);

      // Full / backpressure: BUF_A of 0x10..0x14, only four fit
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'd6, 8'(8'h10 + i), 8'h00);
         if (i == 4) check("full_in_ready_5th", in_ready, 0);
         tick();
      end
      check("full_count", count, 4);
      check("full_in_ready", in_ready, 0);
      check("full_head", out_result, 8'h10);
      // Illegal opcode presented while full is not accepted or counted
      drive(1'b1, 4'hC, 8'hFF, 8'hFF);
      tick();
      check("full_unaccepted_err_cnt", err_cnt, 0);
      check("full_head_stable", out_result, 8'h10);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pop1_in_ready", in_ready, 1);
      check("pop1_count", count, 3);
      check("pop1_head", out_result, 8'h11);
      out_ready = 1'b1;
      tick();
      check("drain_head_12", out_result, 8'h12);
      tick();
      check("drain_head_13", out_result, 8'h13);
      tick();
      check("drain_empty", out_valid, 0);

      // Illegal opcode
      drive(1'b1, 4'hB, 8'hFF, 8'hFF);
      tick();
      check("ill_result", out_result, 8'h00);
      check("ill_err", out_err, 1);
      check("ill_err_cnt", err_cnt, 1);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 4'(4'hA + (i % 6)), 8'(i), 8'hA5);
         tick();
         if (i == 99) check("ill_err_cnt_101", err_cnt, 101);
      end
      check("ill_err_cnt_sat", err_cnt, 255);
      check("ill_err_last", out_err, 1);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      tick();
      check("ill_drained", count, 0);

      // Simultaneous push/pop at count=2, pointers wrap
      out_ready = 1'b0;
      drive(1'b1, 4'd7, 8'h00, 8'h20);
      tick();
      drive(1'b1, 4'd7, 8'h00, 8'h21);
      tick();
      check("sim_pre_count", count, 2);
      check("sim_pre_head", out_result, 8'h20);
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 4'd7, 8'h00, 8'(8'h22 + k));
         tick();
         check($sformatf("sim%0d_count", k), count, 2);
         check($sformatf("sim%0d_head", k), out_result, 8'(8'h21 + k));
         check($sformatf("sim%0d_err", k), out_err, 0);
      end

      // Reset mid-stream with 3 entries queued
      out_ready = 1'b0;
      drive(1'b1, 4'hD, 8'h00, 8'h00);
      tick();
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      check("mid_pre_count", count, 3);
      check("mid_pre_err_cnt", err_cnt, 255);
      rst_n = 1'b0;
      #1;
      check("mid_rst_count", count, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_err_cnt", err_cnt, 0);
      check("mid_rst_out_result", out_result, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // First accept after release (AND 0x07,0x03)
      drive(1'b1, 4'd0, 8'h07, 8'h03);
      tick();
      check("post_rst_valid", out_valid, 1);
      check("post_rst_result", out_result, 8'h03);
      check("post_rst_count", count, 1);
`ifdef LGU_PARITY_EN
      check("parity_and", out_parity, 0);
`endif
      drive(1'b1, 4'd6, 8'h07, 8'h00);
      out_ready = 1'b1;
      tick();
      check("post_rst_buf_a", out_result, 8'h07);
`ifdef LGU_PARITY_EN
      check("parity_buf_a", out_parity, 1);
`endif
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      tick();
      check("final_empty", out_valid, 0);
`ifdef LGU_PARITY_EN
      check("parity_empty", out_parity, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logic_gate_unit.md
# logic_gate_unit

Parametrised, registered successor to the team's single-bit logic-gate DUT. It applies one of ten bitwise logic functions to two WIDTH-bit operands. The function is chosen per transaction by an opcode. Results are buffered in a DEPTH-entry FIFO behind a valid/ready handshake. It sits between a stimulus agent and a result monitor in the logic-gate testbench environment and also serves as the reusable logic ALU slice.

## Interface
- WIDTH, 8: operand and result width, 1..64.
- DEPTH, 4: result FIFO entries, power of two, 2..64.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand and opcode valid.
- in_ready  output  1  unit can accept; equals FIFO not full.
- in_op  input  4  opcode (lgu_pkg::op_e).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_result  output  WIDTH  head result.
- out_err  output  1  head was produced by an illegal opcode.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err_cnt  output  8  saturating count of illegal opcodes accepted.

## Operation
- Accept: the unit accepts when in_valid && in_ready. The result is computed combinationally from in_a, in_b and in_op, and is written with its err flag into the FIFO on the same edge.
- Opcodes:
  - 0 AND, 1 OR, 2 NOT_A, 3 NOT_B, 4 XOR, 5 XNOR, 6 BUF_A, 7 BUF_B, 8 NAND, 9 NOR.
  - All operations are bitwise across WIDTH.
  - 0xA–0xF are illegal: the result is all zeros, err=1, and err_cnt increments.
- Pop: the head is popped when out_valid && out_ready. out_result and out_err show the head entry and are stable while out_valid=1 and out_ready=0.
- FIFO:
  - Circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
  - Occupancy is tracked by an explicit counter.
  - in_ready = (count != DEPTH). out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged and both pointers advance. This is also legal when full (in_ready is 0, so no push occurs) and when empty (no pop occurs).
- err_cnt saturates at 255. It counts accepted illegal opcodes only; presented but unaccepted ones are not counted.
- in_ready does not depend combinationally on out_ready. There is no bypass on the full condition.

## Timing
- Reset values, asynchronous on the falling edge of rst_n:
  - count=0, pointers=0, err_cnt=0.
  - out_valid=0, in_ready=1, out_result=0, out_err=0.
- Reset mid-operation discards all FIFO contents immediately. The first accept after release occurs on the first rising edge with rst_n=1.
- Latency: accept at edge N means out_valid=1 after edge N when the FIFO was empty. The minimum is one cycle from accept to head visibility.
- Throughput: one accept and one pop per cycle, sustained indefinitely when out_ready is held at 1.
- With out_ready held at 0, in_ready falls after DEPTH accepts. It rises the cycle after the first pop.
- Memory contents are not reset. out_result is gated to 0 when out_valid=0.

## Configuration
- LGU_PARITY_EN defined:
  - Adds output port out_parity (1 bit) = XOR-reduce of out_result, plus a matching stored FIFO bit computed at write time.
  - out_parity is 0 when out_valid=0 and resets to 0.
- LGU_PARITY_EN undefined: the port and its storage are absent. All other behaviour is identical.

## Structure
- lgu_pkg holds:
  - typedef enum logic [3:0] op_e with the ten legal opcodes.
  - Constant LGU_ERR_CNT_W = 8.
  - Function lgu_is_legal(op_e).
- One sub-module, lgu_fifo: parametrised by data width and DEPTH; has push/pop/full/empty/count.
- The top-level logic_gate_unit holds the function decode, err_cnt, and the handshake glue.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset: assert rst_n=0 mid-stream with 3 entries queued -> count=0, out_valid=0, in_ready=1, err_cnt=0 immediately.
- All ops: a=0xCA, b=0x5C, op 0..9, out_ready=1 -> results in order 0x48, 0xDE, 0x35, 0xA3, 0x96, 0x69, 0xCA, 0x5C, 0xB7, 0x21; each appears one cycle after accept; out_err=0.
- Illegal: op=0xB, a=0xFF, b=0xFF -> out_result=0x00, out_err=1, err_cnt=1. Then 300 further illegal accepts -> err_cnt=255.
- Full/backpressure: out_ready=0, 5 cycles of in_valid=1 -> 4 accepts, in_ready=0 on the 5th, count=4. Then out_ready=1 for 1 cycle -> in_ready=1 next cycle, count=3.
- Simultaneous push/pop with count=2 and wrap: continuous traffic for 10 transactions -> count stays 2, pointers wrap, order preserved.
- Parity (LGU_PARITY_EN): op=AND, a=0x07, b=0x03 -> out_result=0x03, out_parity=0.
